// File: rtl/rv32i_types.sv
// rv32i_types: shared FSM state and line/burst geometry for the cacheline adapter.
package rv32i_types;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} cla_state_t;
    localparam int BURST_W     = 64;
    localparam int NUM_BURSTS  = 4;
    localparam int LINE_W      = 256;
    localparam int OFFSET_BITS = 5;
endpackage

// File: rtl/cacheline_adapter.sv
// cacheline_adapter: 256-bit line <-> 4x64-bit memory burst converter.
// Define CACHELINE_ADAPTER_WDT_EN to add the sticky watchdog output err_o.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CACHELINE_ADAPTER_WDT_EN
    output logic                err_o,
`endif
    input  logic [LINE_W-1:0]   line_i,
    output logic [LINE_W-1:0]   line_o,
    input  logic [31:0]         address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [BURST_W-1:0]  burst_i,
    output logic [BURST_W-1:0]  burst_o,
    output logic [31:0]         address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);
    cla_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0] rbuf_q, rbuf_d, wbuf_q, wbuf_d;
    logic [31:0]       addr_q, addr_d;
    logic              last;

    assign last = cnt_q == 2'(NUM_BURSTS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rbuf_d  = rbuf_q;
        wbuf_d  = wbuf_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (write_i) begin
                    wbuf_d  = line_i;
                    addr_d  = address_i;
                    state_d = WRITE;
                end else if (read_i) begin
                    addr_d  = address_i;
                    state_d = READ;
                end
            end
            READ: begin
                if (resp_i) begin
                    rbuf_d[BURST_W*cnt_q +: BURST_W] = burst_i;
                    cnt_d   = cnt_q + 2'd1;
                    state_d = last ? DONE : READ;
                end
            end
            WRITE: begin
                if (resp_i) begin
                    cnt_d   = cnt_q + 2'd1;
                    state_d = last ? DONE : WRITE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            wbuf_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rbuf_q  <= rbuf_d;
            wbuf_q  <= wbuf_d;
            addr_q  <= addr_d;
        end
    end

    assign line_o    = rbuf_q;
    assign read_o    = state_q == READ;
    assign write_o   = state_q == WRITE;
    assign resp_o    = state_q == DONE;
    assign burst_o   = write_o ? wbuf_q[BURST_W*cnt_q +: BURST_W] : '0;
    assign address_o = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

`ifdef CACHELINE_ADAPTER_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT + 1);
    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             err_q, err_d, busy, hit;

    assign busy = read_o | write_o;
    assign hit  = wdt_q == WDT_W'(TIMEOUT);

    // Counter saturates at TIMEOUT so the error flag never depends on wrap-around.
    always_comb begin
        wdt_d = (!busy || resp_i) ? '0 : hit ? wdt_q : wdt_q + 1'b1;
        err_d = err_q | (busy && hit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_q <= '0;
            err_q <= 1'b0;
        end else begin
            wdt_q <= wdt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif
endmodule

// File: tb/tb_cacheline_adapter.sv
// tb_cacheline_adapter: directed scoreboard bench for cacheline_adapter.
module tb_cacheline_adapter;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o, read_o, write_o, resp_i;
    logic [63:0]  burst_i, burst_o;
`ifdef CACHELINE_ADAPTER_WDT_EN
    logic         err_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [255:0] exp_q[$];
    logic [63:0]  beat_q[$];
    logic [255:0] last_line = '0;
    logic         prev_resp = 1'b0;

    always #5 clk = ~clk;

`ifdef CACHELINE_ADAPTER_WDT_EN
    cacheline_adapter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .err_o(err_o),
`else
    cacheline_adapter dut (
        .clk(clk), .rst(rst),
`endif
        .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i));

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops expected lines on resp_o and expected write beats on accepted beats.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (resp_o) begin
                chk("resp_pulse_prev", {255'b0, prev_resp}, 256'd0);
                if (exp_q.size() == 0) chk("unexpected_resp", 256'd1, 256'd0);
                else chk("line_o", line_o, exp_q.pop_front());
            end
            if (write_o && resp_i) begin
                if (beat_q.size() == 0) chk("unexpected_beat", 256'd1, 256'd0);
                else chk("burst_o", {192'b0, burst_o}, {192'b0, beat_q.pop_front()});
            end
        end
        prev_resp = resp_o;
    end

    task automatic run(input logic w, input logic r, input logic [31:0] addr,
                       input logic [255:0] wl, input logic [255:0] rl, input int gap);
        write_i = w; read_i = r; address_i = addr; line_i = wl;
        if (w) begin
            for (int i = 0; i < 4; i++) beat_q.push_back(wl[64*i +: 64]);
            exp_q.push_back(last_line);
        end else begin
            last_line = rl;
            exp_q.push_back(rl);
        end
        tick();
        chk("write_o_start", {255'b0, write_o}, {255'b0, w});
        chk("read_o_start", {255'b0, read_o}, {255'b0, ~w});
        chk("address_o", {224'b0, address_o}, {224'b0, addr[31:5], 5'b0});
        for (int i = 0; i < 4; i++) begin
            resp_i = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            resp_i = 1'b1;
            burst_i = rl[64*i +: 64];
            tick();
            if (i < 3) chk("resp_early", {255'b0, resp_o}, 256'd0);
        end
        resp_i = 1'b0;
        burst_i = '0;
        chk("resp_lat", {255'b0, resp_o}, 256'd1);
        chk("strobe_drop", {254'b0, read_o, write_o}, 256'd0);
        write_i = 1'b0; read_i = 1'b0;
        tick();
        chk("resp_single", {255'b0, resp_o}, 256'd0);
    endtask

    localparam logic [255:0] L_A = {64'hAAAA_0003_0003_0003, 64'hAAAA_0002_0002_0002,
                                    64'hAAAA_0001_0001_0001, 64'hAAAA_0000_0000_0000};
    localparam logic [255:0] L_B = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L_W = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
                                    64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
    localparam logic [255:0] L_C = {64'hCAFE_0000_0000_0004, 64'hCAFE_0000_0000_0003,
                                    64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0001};
    localparam logic [255:0] L_V = {64'h5A5A_5A5A_5A5A_5A5A, 64'h0F0F_0F0F_0F0F_0F0F,
                                    64'hF0F0_F0F0_F0F0_F0F0, 64'hA5A5_A5A5_A5A5_A5A5};

    initial begin
        rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
        line_i = '0; address_i = '0; burst_i = '0;
        tick(); tick();
        chk("rst_outputs", {line_o, 32'b0} ^ {burst_o, address_o, resp_o, read_o, write_o, 157'b0}, 256'd0);
        chk("rst_line_o", line_o, 256'd0);
        rst = 1'b0;
        tick();
        // Abort a read after two beats with an asynchronous reset.
        read_i = 1'b1; address_i = 32'h0000_2000;
        tick();
        for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1; burst_i = 64'hBAD0_0000_0000_0000 | 64'(i); tick();
        end
        resp_i = 1'b0; read_i = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_ctrl", {252'b0, read_o, write_o, resp_o, |burst_o}, 256'd0);
        chk("midrst_addr", {224'b0, address_o}, 256'd0);
        chk("midrst_line", line_o, 256'd0);
        tick();
        rst = 1'b0;
        tick();
        run(1'b0, 1'b1, 32'h0000_1000, '0, L_A, 0);
        run(1'b0, 1'b1, 32'h8000_1234, '0, L_B, 0);
        run(1'b1, 1'b0, 32'h0000_0040, L_W, '0, 0);
        run(1'b0, 1'b1, 32'h0000_3FFF, '0, L_C, 3);
        // Stray memory acknowledges while idle must not advance anything.
        resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick(); tick(); tick();
        chk("idle_resp", {253'b0, resp_o, read_o, write_o}, 256'd0);
        chk("idle_line", line_o, L_C);
        resp_i = 1'b0;
        tick();
        run(1'b1, 1'b1, 32'hFFFF_FFE7, L_V, '0, 1);
        run(1'b0, 1'b1, 32'h1234_5678, '0, L_V, 2);
`ifdef CACHELINE_ADAPTER_WDT_EN
        chk("wdt_idle", {255'b0, err_o}, 256'd0);
        read_i = 1'b1; address_i = 32'h0000_0100;
        for (int i = 0; i < 22; i++) tick();
        chk("wdt_err", {255'b0, err_o}, 256'd1);
        read_i = 1'b0;
        tick();
        chk("wdt_sticky", {255'b0, err_o}, 256'd1);
        rst = 1'b1; #1;
        chk("wdt_rst", {255'b0, err_o}, 256'd0);
        tick(); rst = 1'b0; tick();
`endif
        tick(); tick();
        chk("exp_q_drained", 256'(exp_q.size()), 256'd0);
        chk("beat_q_drained", 256'(beat_q.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
